md_ctrl: RTL and testbench

Multiply/divide sequencer for the five-stage pipeline. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and owns the HI/LO registers. Models the multi-cycle latency with a busy counter, and raises a stall request to the hazard unit while a D-stage instruction needs HI/LO before the result is committed.

---
 rtl/md_pkg.sv | 30 +++
 rtl/md_ctrl_if.sv | 34 +++
 rtl/md_ctrl_calc.sv | 69 ++++++
 rtl/md_ctrl.sv | 96 +++++++++
 tb/tb_md_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide sequencer:
//   - 3-bit md op codes (MD_MULT .. MD_MTLO)
//   - default busy durations for multiply and divide
//   - is_md_busy_op(): true for the ops that occupy the unit for several cycles
// -----------------------------------------------------------------------------
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // Multi-cycle ops: these load the busy counter and defer the HI/LO write.
    function automatic logic is_md_busy_op(input logic [2:0] op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_ctrl_if.sv
// -----------------------------------------------------------------------------
// md_ctrl_if
// Bundles the E-stage request, the D-stage hazard query and the HI/LO results
// of the multiply/divide sequencer.
//   start, op, a, b : E-stage md instruction and its forwarded operands
//   md_use_d        : D-stage instruction touches mult/div or HI/LO
//   hi, lo          : architectural HI/LO registers
//   busy            : multi-cycle operation in flight
//   stall_md        : stall request towards the hazard unit
// master = pipeline side, slave = md_ctrl.
// -----------------------------------------------------------------------------
interface md_ctrl_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall_md;

    modport master (
        output start, op, a, b, md_use_d,
        input  hi, lo, busy, stall_md
    );

    modport slave (
        input  start, op, a, b, md_use_d,
        output hi, lo, busy, stall_md
    );

endinterface

// File: rtl/md_ctrl_calc.sv
// -----------------------------------------------------------------------------
// md_calc
// Purely combinational arithmetic core of the md sequencer.
//   a, b   : operands (a = rs / dividend, b = rt / divisor)
//   op     : md op code
//   res_hi : product[63:32] or remainder
//   res_lo : product[31:0]  or quotient
//   div0   : divide op with b == 0 (caller must not commit the result)
// Division truncates toward zero; the remainder takes the dividend's sign.
// -----------------------------------------------------------------------------
module md_calc
    import md_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic               b_zero_s;
    logic [31:0]        divisor_s;
    logic signed [63:0] prod_signed_s;
    logic [63:0]        prod_unsigned_s;
    logic signed [31:0] quo_signed_s;
    logic signed [31:0] rem_signed_s;
    logic [31:0]        quo_unsigned_s;
    logic [31:0]        rem_unsigned_s;

    assign b_zero_s = (b == 32'd0);
    // A zero divisor is replaced so the dividers never see x/0; the result is
    // discarded anyway through div0.
    assign divisor_s = b_zero_s ? 32'd1 : b;

    assign prod_signed_s   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_unsigned_s = {32'd0, a} * {32'd0, b};
    assign quo_signed_s    = $signed(a) / $signed(divisor_s);
    assign rem_signed_s    = $signed(a) % $signed(divisor_s);
    assign quo_unsigned_s  = a / divisor_s;
    assign rem_unsigned_s  = a % divisor_s;

    // Result selection by op code.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_signed_s;
            MD_MULTU: {res_hi, res_lo} = prod_unsigned_s;
            MD_DIV: begin
                res_hi = rem_signed_s;
                res_lo = quo_signed_s;
                div0   = b_zero_s;
            end
            MD_DIVU: begin
                res_hi = rem_unsigned_s;
                res_lo = quo_unsigned_s;
                div0   = b_zero_s;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
                div0   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// -----------------------------------------------------------------------------
// md_ctrl
// Multiply/divide sequencer. Owns HI/LO, models the multi-cycle latency with a
// down-counter and requests a stall while a D-stage HI/LO user would otherwise
// overtake an uncommitted result.
//   clk   : pipeline clock
//   reset : asynchronous active-low reset (clears everything, no commit)
//   md    : md_ctrl_if.slave (start/op/a/b/md_use_d in, hi/lo/busy/stall_md out)
// The result is computed at the start edge and parked in pend_hi/pend_lo; it is
// written to HI/LO on the edge where the counter goes 1 -> 0. Starts arriving
// while busy are dropped.
// -----------------------------------------------------------------------------
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
    input  logic       clk,
    input  logic       reset,
    md_ctrl_if.slave   md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic [31:0]      pend_hi_r;
    logic [31:0]      pend_lo_r;
    logic             pend_div0_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic [31:0]      res_hi_s;
    logic [31:0]      res_lo_s;
    logic             div0_s;

    md_calc u_calc (
        .a      (md.a),
        .b      (md.b),
        .op     (md.op),
        .res_hi (res_hi_s),
        .res_lo (res_lo_s),
        .div0   (div0_s)
    );

    // Sequencer state: counter, pending result and the architectural HI/LO.
    // busy_r is kept as its own flop so it mirrors (cnt_r != 0) as a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r       <= CNT_ZERO;
            busy_r      <= 1'b0;
            pend_hi_r   <= 32'd0;
            pend_lo_r   <= 32'd0;
            pend_div0_r <= 1'b0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
                busy_r <= 1'b0;
                if (!pend_div0_r) begin
                    hi_r <= pend_hi_r;
                    lo_r <= pend_lo_r;
                end
            end
        end else if (md.start) begin
            case (md.op)
                MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                    pend_hi_r   <= res_hi_s;
                    pend_lo_r   <= res_lo_s;
                    pend_div0_r <= div0_s;
                    busy_r      <= 1'b1;
                    cnt_r       <= (md.op == MD_MULT || md.op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
                end
                MD_MTHI: hi_r <= md.a;
                MD_MTLO: lo_r <= md.a;
                default: ;
            endcase
        end
    end

    // The start-cycle term keeps a dependent D-stage instruction from slipping
    // past an op that has not yet raised busy.
    assign md.stall_md = md.md_use_d & (busy_r | (md.start & is_md_busy_op(md.op)));
    assign md.busy     = busy_r;
    assign md.hi       = hi_r;
    assign md.lo       = lo_r;

endmodule

// File: tb/tb_md_ctrl.sv
module tb_md_ctrl;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    md_ctrl_if mif ();

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: HI/LO after an op, computed from the arithmetic rules.
    task automatic model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cyc);
        longint sa, sb, qm, rm, q, r;
        longint unsigned ua, ub, p;
        cyc = 0;
        case (op)
            3'd0: begin sa = $signed(a); sb = $signed(b); p = sa * sb;
                        exp_hi = p[63:32]; exp_lo = p[31:0]; cyc = 5; end
            3'd1: begin ua = a; ub = b; p = ua * ub;
                        exp_hi = p[63:32]; exp_lo = p[31:0]; cyc = 5; end
            3'd2: begin
                cyc = 10;
                if (b != 32'd0) begin
                    sa = $signed(a); sb = $signed(b);
                    qm = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
                    rm = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
                    q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
                    r  = (sa < 0) ? -rm : rm;
                    exp_lo = q[31:0]; exp_hi = r[31:0];
                end
            end
            3'd3: begin
                cyc = 10;
                if (b != 32'd0) begin exp_lo = a / b; exp_hi = a % b; end
            end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: cyc = 0;
        endcase
    endtask

    // Count negedges with busy=1; returns at the first negedge with busy=0.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!mif.busy) break;
            n++;
        end
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int n);
        @(negedge clk);
        mif.start = 1'b1; mif.op = op; mif.a = a; mif.b = b;
        @(posedge clk); #1;
        mif.start = 1'b0;
        wait_idle(n);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mif.md_use_d = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        exp_hi = 32'd0; exp_lo = 32'd0;
        total_cnt++; if (mif.hi !== 32'd0) $display("FAIL reset_hi got %h want 0", mif.hi); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'd0) $display("FAIL reset_lo got %h want 0", mif.lo); else pass_cnt++;
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", mif.busy); else pass_cnt++;
        total_cnt++; if (mif.stall_md !== 1'b0) $display("FAIL reset_stall got %b want 0", mif.stall_md); else pass_cnt++;
        mif.md_use_d = 1'b0;
    endtask

    task automatic test_mult();
        int n, e;
        model_op(3'd0, 32'hFFFFFFFE, 32'd3, e);
        run_op(3'd0, 32'hFFFFFFFE, 32'd3, n);
        total_cnt++; if (n !== 5) $display("FAIL mult_busy got %0d want 5", n); else pass_cnt++;
        total_cnt++; if (mif.hi !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want FFFFFFFF", mif.hi); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'hFFFFFFFA) $display("FAIL mult_lo got %h want FFFFFFFA", mif.lo); else pass_cnt++;
        model_op(3'd1, 32'hFFFFFFFE, 32'd3, e);
        run_op(3'd1, 32'hFFFFFFFE, 32'd3, n);
        total_cnt++; if (n !== 5) $display("FAIL multu_busy got %0d want 5", n); else pass_cnt++;
        total_cnt++; if (mif.hi !== 32'h00000002) $display("FAIL multu_hi got %h want 00000002", mif.hi); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'hFFFFFFFA) $display("FAIL multu_lo got %h want FFFFFFFA", mif.lo); else pass_cnt++;
    endtask

    task automatic test_div();
        int n, e;
        model_op(3'd2, 32'hFFFFFFF9, 32'd2, e);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, n);
        total_cnt++; if (n !== 10) $display("FAIL div_busy got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'hFFFFFFFD) $display("FAIL div_lo got %h want FFFFFFFD", mif.lo); else pass_cnt++;
        total_cnt++; if (mif.hi !== 32'hFFFFFFFF) $display("FAIL div_hi got %h want FFFFFFFF", mif.hi); else pass_cnt++;
        model_op(3'd3, 32'd7, 32'd0, e);
        run_op(3'd3, 32'd7, 32'd0, n);
        total_cnt++; if (n !== 10) $display("FAIL divu0_busy got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'hFFFFFFFD) $display("FAIL divu0_lo got %h want FFFFFFFD", mif.lo); else pass_cnt++;
        total_cnt++; if (mif.hi !== 32'hFFFFFFFF) $display("FAIL divu0_hi got %h want FFFFFFFF", mif.hi); else pass_cnt++;
    endtask

    task automatic test_mt();
        int e;
        model_op(3'd4, 32'h12345678, 32'd0, e);
        model_op(3'd5, 32'h9ABCDEF0, 32'd0, e);
        @(negedge clk);
        mif.start = 1'b1; mif.op = 3'd4; mif.a = 32'h12345678;
        @(negedge clk);
        total_cnt++; if (mif.hi !== 32'h12345678) $display("FAIL mthi_hi got %h want 12345678", mif.hi); else pass_cnt++;
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL mthi_busy got %b want 0", mif.busy); else pass_cnt++;
        mif.op = 3'd5; mif.a = 32'h9ABCDEF0;
        @(negedge clk);
        mif.start = 1'b0;
        total_cnt++; if (mif.lo !== 32'h9ABCDEF0) $display("FAIL mtlo_lo got %h want 9ABCDEF0", mif.lo); else pass_cnt++;
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL mtlo_busy got %b want 0", mif.busy); else pass_cnt++;
    endtask

    task automatic test_stall();
        int e;
        model_op(3'd0, 32'd5, 32'd7, e);
        mif.md_use_d = 1'b1;
        @(negedge clk);
        mif.start = 1'b1; mif.op = 3'd0; mif.a = 32'd5; mif.b = 32'd7;
        #1;
        total_cnt++; if (mif.stall_md !== 1'b1) $display("FAIL stall_start got %b want 1", mif.stall_md); else pass_cnt++;
        @(posedge clk); #1;
        mif.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total_cnt++; if (mif.stall_md !== 1'b1) $display("FAIL stall_busy%0d got %b want 1", i, mif.stall_md); else pass_cnt++;
            total_cnt++; if (mif.busy !== 1'b1) $display("FAIL busy_cyc%0d got %b want 1", i, mif.busy); else pass_cnt++;
            // Starts issued while busy must be dropped.
            if (i == 1) begin mif.start = 1'b1; mif.op = 3'd4; mif.a = 32'hDEADBEEF; end
            if (i == 2) begin mif.op = 3'd2; mif.a = 32'd1000; mif.b = 32'd3; end
            if (i == 3) mif.start = 1'b0;
        end
        @(negedge clk);
        total_cnt++; if (mif.stall_md !== 1'b0) $display("FAIL stall_drop got %b want 0", mif.stall_md); else pass_cnt++;
        total_cnt++; if (mif.hi !== exp_hi) $display("FAIL ignore_hi got %h want %h", mif.hi, exp_hi); else pass_cnt++;
        total_cnt++; if (mif.lo !== exp_lo) $display("FAIL ignore_lo got %h want %h", mif.lo, exp_lo); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL ignore_busy got %b want 0", mif.busy); else pass_cnt++;
        mif.md_use_d = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, e;
        model_op(3'd1, 32'h0001_0000, 32'h0003_0000, e);
        run_op(3'd1, 32'h0001_0000, 32'h0003_0000, n);
        total_cnt++; if (mif.hi !== exp_hi || mif.lo !== exp_lo)
            $display("FAIL b2b_first got %h_%h want %h_%h", mif.hi, mif.lo, exp_hi, exp_lo); else pass_cnt++;
        // Start on the very first idle cycle.
        model_op(3'd3, 32'd100, 32'd7, e);
        mif.start = 1'b1; mif.op = 3'd3; mif.a = 32'd100; mif.b = 32'd7;
        @(posedge clk); #1;
        mif.start = 1'b0;
        wait_idle(n);
        total_cnt++; if (n !== 10) $display("FAIL b2b_busy got %0d want 10", n); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'd14) $display("FAIL b2b_lo got %h want 0000000e", mif.lo); else pass_cnt++;
        total_cnt++; if (mif.hi !== 32'd2) $display("FAIL b2b_hi got %h want 00000002", mif.hi); else pass_cnt++;
    endtask

    task automatic test_random();
        int n, e, sel;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int k = 0; k < 30; k++) begin
            op  = 3'($urandom_range(0, 7));
            a   = $urandom;
            sel = $urandom_range(0, 3);
            b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 16)) : $urandom;
            if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
            model_op(op, a, b, e);
            run_op(op, a, b, n);
            total_cnt++; if (n !== e) $display("FAIL rnd%0d_busy op %0d got %0d want %0d", k, op, n, e); else pass_cnt++;
            total_cnt++; if (mif.hi !== exp_hi) $display("FAIL rnd%0d_hi op %0d a %h b %h got %h want %h", k, op, a, b, mif.hi, exp_hi); else pass_cnt++;
            total_cnt++; if (mif.lo !== exp_lo) $display("FAIL rnd%0d_lo op %0d a %h b %h got %h want %h", k, op, a, b, mif.lo, exp_lo); else pass_cnt++;
        end
    endtask

    task automatic test_reset_mid();
        int n, e;
        model_op(3'd4, 32'hA5A5A5A5, 32'd0, e);
        run_op(3'd4, 32'hA5A5A5A5, 32'd0, n);
        model_op(3'd5, 32'h5A5A5A5A, 32'd0, e);
        run_op(3'd5, 32'h5A5A5A5A, 32'd0, n);
        @(negedge clk);
        mif.start = 1'b1; mif.op = 3'd2; mif.a = 32'd100; mif.b = 32'd3;
        @(posedge clk); #1;
        mif.start = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (mif.busy !== 1'b1) $display("FAIL rstmid_pre_busy got %b want 1", mif.busy); else pass_cnt++;
        mif.md_use_d = 1'b1;
        reset = 1'b0;
        #1;
        exp_hi = 32'd0; exp_lo = 32'd0;
        total_cnt++; if (mif.hi !== 32'd0) $display("FAIL rstmid_hi got %h want 0", mif.hi); else pass_cnt++;
        total_cnt++; if (mif.lo !== 32'd0) $display("FAIL rstmid_lo got %h want 0", mif.lo); else pass_cnt++;
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", mif.busy); else pass_cnt++;
        total_cnt++; if (mif.stall_md !== 1'b0) $display("FAIL rstmid_stall got %b want 0", mif.stall_md); else pass_cnt++;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        total_cnt++; if (mif.hi !== 32'd0 || mif.lo !== 32'd0)
            $display("FAIL rstmid_nocommit got %h_%h want 0_0", mif.hi, mif.lo); else pass_cnt++;
        total_cnt++; if (mif.busy !== 1'b0) $display("FAIL rstmid_idle got %b want 0", mif.busy); else pass_cnt++;
        mif.md_use_d = 1'b0;
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        reset = 1'b0;
        mif.start = 1'b0; mif.op = 3'd0; mif.a = 32'd0; mif.b = 32'd0; mif.md_use_d = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
